// File: rtl/team_turn_scheduler_if.sv
// Match-control bus between the per-life status controller side and the
// team turn scheduler.
//   master : drives game_status, eat_pulse, clear_match; observes results
//   slave  : the scheduler; consumes status/events, drives team, round,
//            scores, time_up, game_complete and winner
interface team_turn_scheduler_if #(
  parameter int unsigned SCORE_W = 8
);
  logic [1:0]         game_status;   // 00 RESTART, 01 START, 10 PLAY, 11 DIE
  logic               eat_pulse;
  logic               clear_match;
  logic               active_team;   // 0 = team A, 1 = team B
  logic [7:0]         round_idx;
  logic [SCORE_W-1:0] score_a;
  logic [SCORE_W-1:0] score_b;
  logic               time_up;
  logic               game_complete;
  logic [1:0]         winner;        // 01 A, 10 B, 11 tie, 00 not finished

  modport master (
    output game_status, eat_pulse, clear_match,
    input  active_team, round_idx, score_a, score_b, time_up,
           game_complete, winner
  );

  modport slave (
    input  game_status, eat_pulse, clear_match,
    output active_team, round_idx, score_a, score_b, time_up,
           game_complete, winner
  );
endinterface

// File: rtl/team_turn_scheduler.sv
// Match-level controller for the two-team snake game.
// Watches the per-life status sequence, alternates teams A/B over
// ROUNDS_PER_TEAM rounds, limits each turn to TURN_CYCLES PLAY cycles
// (signalling expiry with a one-cycle time_up), accumulates saturating
// scores and reports game_complete/winner once every turn has been played.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : team_turn_scheduler_if.slave (status/events in, match state out)
// All outputs are registered.
module team_turn_scheduler #(
  parameter int unsigned ROUNDS_PER_TEAM = 2,
  parameter int unsigned TURN_CYCLES     = 1_500_000_000,
  parameter int unsigned SCORE_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  team_turn_scheduler_if.slave   bus
);

  localparam logic [1:0]  ST_RESTART = 2'b00;
  localparam logic [1:0]  ST_PLAY    = 2'b10;
  localparam logic [1:0]  ST_DIE     = 2'b11;
  localparam logic [31:0] TIMER_LOAD = 32'(TURN_CYCLES - 1);
  localparam logic [7:0]  LAST_ROUND = 8'(ROUNDS_PER_TEAM - 1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_RUN,
    S_END,
    S_DONE
  } state_t;

  state_t             state;
  logic [31:0]        timer;
  logic               active_team;
  logic [7:0]         round_idx;
  logic [SCORE_W-1:0] score_a;
  logic [SCORE_W-1:0] score_b;
  logic               time_up;
  logic               game_complete;
  logic [1:0]         winner;
  logic [1:0]         final_winner;

  // Scores are frozen from END onward, so the comparison taken on the
  // final END->DONE transition already reflects the final result.
  always_comb begin
    final_winner = 2'b11;
    if (score_a > score_b)
      final_winner = 2'b01;
    else if (score_b > score_a)
      final_winner = 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear_match) begin
      state         <= S_WAIT;
      timer         <= '0;
      active_team   <= 1'b0;
      round_idx     <= '0;
      score_a       <= '0;
      score_b       <= '0;
      time_up       <= 1'b0;
      game_complete <= 1'b0;
      winner        <= 2'b00;
    end else begin
      time_up <= 1'b0;
      case (state)
        S_WAIT: begin
          if (bus.game_status == ST_PLAY) begin
            timer <= TIMER_LOAD;
            state <= S_RUN;
          end
        end

        S_RUN: begin
          // A food eaten on the exit cycle still counts.
          if (bus.eat_pulse) begin
            if (!active_team) begin
              if (score_a != '1)
                score_a <= score_a + 1'b1;
            end else begin
              if (score_b != '1)
                score_b <= score_b + 1'b1;
            end
          end
          if (bus.game_status == ST_DIE) begin
            state <= S_END;
          end else if (timer == '0) begin
            time_up <= 1'b1;
            state   <= S_END;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_END: begin
          // Leaving END on the first RESTART lets the remaining RESTART
          // cycles be absorbed by WAIT, so a long RESTART advances once.
          if (bus.game_status == ST_RESTART) begin
            if (!active_team) begin
              active_team <= 1'b1;
              state       <= S_WAIT;
            end else if (round_idx < LAST_ROUND) begin
              active_team <= 1'b0;
              round_idx   <= round_idx + 1'b1;
              state       <= S_WAIT;
            end else begin
              game_complete <= 1'b1;
              winner        <= final_winner;
              state         <= S_DONE;
            end
          end
        end

        S_DONE: begin
          game_complete <= 1'b1;
        end

        default: state <= S_WAIT;
      endcase
    end
  end

  assign bus.active_team   = active_team;
  assign bus.round_idx     = round_idx;
  assign bus.score_a       = score_a;
  assign bus.score_b       = score_b;
  assign bus.time_up       = time_up;
  assign bus.game_complete = game_complete;
  assign bus.winner        = winner;

endmodule

// File: tb/tb_team_turn_scheduler.sv
module tb_team_turn_scheduler;
  localparam int unsigned R  = 2;
  localparam int unsigned TC = 10;
  localparam logic [1:0] RS = 2'b00, SA = 2'b01, PL = 2'b10, DI = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  team_turn_scheduler_if #(.SCORE_W(8)) bus ();
  team_turn_scheduler_if #(.SCORE_W(3)) sbus ();

  team_turn_scheduler #(.ROUNDS_PER_TEAM(R), .TURN_CYCLES(TC), .SCORE_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  team_turn_scheduler #(.ROUNDS_PER_TEAM(R), .TURN_CYCLES(TC), .SCORE_W(3)) dut_sat (
    .clk(clk), .rst(rst), .bus(sbus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] st;
    logic       eat;
    logic       clr;
    logic       team;
    logic [7:0] rnd;
    logic [7:0] sa;
    logic [7:0] sb;
    logic       tu;
    logic       gc;
    logic [1:0] win;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(logic [1:0] st, logic eat, logic clr, logic team,
                               int rnd, int sa, int sb, logic tu, logic gc, logic [1:0] win);
    vec_t v;
    v.st = st; v.eat = eat; v.clr = clr; v.team = team;
    v.rnd = 8'(rnd); v.sa = 8'(sa); v.sb = 8'(sb);
    v.tu = tu; v.gc = gc; v.win = win;
    return v;
  endfunction

  function automatic logic [31:0] pack_out();
    return {bus.active_team, bus.round_idx, bus.score_a, bus.score_b,
            bus.time_up, bus.game_complete, bus.winner, 3'b000};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] st, input logic eat, input logic clr);
    bus.game_status = st;
    bus.eat_pulse   = eat;
    bus.clear_match = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic sstep(input logic [1:0] st, input logic eat);
    sbus.game_status = st;
    sbus.eat_pulse   = eat;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.game_status = RS; bus.eat_pulse = 1'b0; bus.clear_match = 1'b0;
    sbus.game_status = RS; sbus.eat_pulse = 1'b0; sbus.clear_match = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference model: a match is a list of 2*R turns; turn t belongs to
  // team t%2 in round t/2. Each turn is waiting -> playing -> over.
  int  m_turn;
  bit  m_playing, m_over, m_fin, m_tu;
  int  m_elapsed;
  int  m_sc[2];

  task automatic m_reset();
    m_turn = 0; m_playing = 0; m_over = 0; m_fin = 0; m_tu = 0;
    m_elapsed = 0; m_sc[0] = 0; m_sc[1] = 0;
  endtask

  task automatic m_step(input logic [1:0] st, input logic eat, input logic clr);
    m_tu = 0;
    if (clr) begin
      m_reset();
    end else if (m_fin) begin
      // frozen
    end else if (m_playing) begin
      if (eat) m_sc[m_turn % 2] = (m_sc[m_turn % 2] >= 255) ? 255 : m_sc[m_turn % 2] + 1;
      if (st == DI) begin
        m_playing = 0; m_over = 1;
      end else if (m_elapsed == int'(TC) - 1) begin
        m_tu = 1; m_playing = 0; m_over = 1;
      end else begin
        m_elapsed++;
      end
    end else if (m_over) begin
      if (st == RS) begin
        m_over = 0;
        if (m_turn == 2 * int'(R) - 1) m_fin = 1;
        else m_turn++;
      end
    end else if (st == PL) begin
      m_playing = 1; m_elapsed = 0;
    end
  endtask

  function automatic logic [31:0] m_pack();
    logic [1:0] w;
    w = 2'b00;
    if (m_fin) w = (m_sc[0] > m_sc[1]) ? 2'b01 : (m_sc[1] > m_sc[0]) ? 2'b10 : 2'b11;
    return {1'(m_turn % 2), 8'(m_turn / 2), 8'(m_sc[0]), 8'(m_sc[1]),
            1'(m_tu), 1'(m_fin), w, 3'b000};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tu_first, tu_count;
    logic [1:0] st;

    // ---------- reset state ----------
    do_reset();
    chk("reset_outputs", pack_out(), 32'h0);

    // ---------- table-driven turn/scoring sequence ----------
    tbl.push_back(mkv(PL, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    tbl.push_back(mkv(PL, 1, 0, 0, 0, 1, 0, 0, 0, 2'b00));
    tbl.push_back(mkv(PL, 1, 0, 0, 0, 2, 0, 0, 0, 2'b00));
    tbl.push_back(mkv(DI, 1, 0, 0, 0, 3, 0, 0, 0, 2'b00));  // eat with DIE counts
    tbl.push_back(mkv(DI, 1, 0, 0, 0, 3, 0, 0, 0, 2'b00));  // eat in END ignored
    tbl.push_back(mkv(RS, 0, 0, 1, 0, 3, 0, 0, 0, 2'b00));
    tbl.push_back(mkv(RS, 1, 0, 1, 0, 3, 0, 0, 0, 2'b00));  // eat in WAIT ignored
    tbl.push_back(mkv(RS, 0, 0, 1, 0, 3, 0, 0, 0, 2'b00));
    tbl.push_back(mkv(SA, 0, 0, 1, 0, 3, 0, 0, 0, 2'b00));
    tbl.push_back(mkv(PL, 1, 0, 1, 0, 3, 0, 0, 0, 2'b00));  // still WAIT on this edge
    tbl.push_back(mkv(PL, 1, 0, 1, 0, 3, 1, 0, 0, 2'b00));
    tbl.push_back(mkv(PL, 1, 0, 1, 0, 3, 2, 0, 0, 2'b00));
    tbl.push_back(mkv(PL, 1, 0, 1, 0, 3, 3, 0, 0, 2'b00));
    tbl.push_back(mkv(PL, 1, 0, 1, 0, 3, 4, 0, 0, 2'b00));
    tbl.push_back(mkv(DI, 1, 0, 1, 0, 3, 5, 0, 0, 2'b00));
    tbl.push_back(mkv(RS, 0, 0, 0, 1, 3, 5, 0, 0, 2'b00));
    tbl.push_back(mkv(RS, 0, 0, 0, 1, 3, 5, 0, 0, 2'b00));
    tbl.push_back(mkv(PL, 0, 0, 0, 1, 3, 5, 0, 0, 2'b00));
    tbl.push_back(mkv(DI, 0, 0, 0, 1, 3, 5, 0, 0, 2'b00));
    tbl.push_back(mkv(RS, 0, 0, 1, 1, 3, 5, 0, 0, 2'b00));
    tbl.push_back(mkv(PL, 0, 0, 1, 1, 3, 5, 0, 0, 2'b00));
    tbl.push_back(mkv(DI, 0, 0, 1, 1, 3, 5, 0, 0, 2'b00));
    tbl.push_back(mkv(RS, 0, 0, 1, 1, 3, 5, 0, 1, 2'b10));  // match complete, B wins
    tbl.push_back(mkv(RS, 0, 0, 1, 1, 3, 5, 0, 1, 2'b10));
    tbl.push_back(mkv(PL, 1, 0, 1, 1, 3, 5, 0, 1, 2'b10));  // DONE frozen
    tbl.push_back(mkv(DI, 1, 0, 1, 1, 3, 5, 0, 1, 2'b10));
    tbl.push_back(mkv(RS, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));  // clear_match in DONE
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].st, tbl[i].eat, tbl[i].clr);
      chk($sformatf("vec%0d", i), pack_out(),
          {tbl[i].team, tbl[i].rnd, tbl[i].sa, tbl[i].sb, tbl[i].tu, tbl[i].gc, tbl[i].win, 3'b000});
    end

    // ---------- full match: 3 PLAY cycles, DIE, 7 RESTART cycles ----------
    do_reset();
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 3; k++) step(PL, 1'b0, 1'b0);
      chk($sformatf("match_team_t%0d", t), 64'(bus.active_team), 64'(t % 2));
      chk($sformatf("match_round_t%0d", t), 64'(bus.round_idx), 64'(t / 2));
      step(DI, 1'b0, 1'b0);
      chk($sformatf("match_gc_pre_t%0d", t), 64'(bus.game_complete), 64'd0);
      for (int k = 0; k < 7; k++) begin
        step(RS, 1'b0, 1'b0);
        if (t == 3 && k == 0) begin
          chk("match_gc_rise", 64'(bus.game_complete), 64'd1);
          chk("match_winner_tie", 64'(bus.winner), 64'd3);
        end
      end
      if (t < 3) begin
        chk($sformatf("restart_team_t%0d", t), 64'(bus.active_team), 64'((t + 1) % 2));
        chk($sformatf("restart_round_t%0d", t), 64'(bus.round_idx), 64'((t + 1) / 2));
      end
    end
    chk("match_gc_held", 64'(bus.game_complete), 64'd1);

    // ---------- timeout with PLAY held ----------
    do_reset();
    tu_first = 0; tu_count = 0;
    for (int n = 1; n <= 20; n++) begin
      step(PL, (n > 11) ? 1'b1 : 1'b0, 1'b0);
      if (bus.time_up === 1'b1) begin
        tu_count++;
        if (tu_first == 0) tu_first = n;
      end
    end
    chk("timeout_edge", 64'(tu_first), 64'd11);
    chk("timeout_width", 64'(tu_count), 64'd1);
    chk("timeout_in_end_score", 64'(bus.score_a), 64'd0);
    step(RS, 1'b0, 1'b0);
    chk("timeout_end_restart", 64'(bus.active_team), 64'd1);

    // ---------- DIE on the timer-zero cycle ----------
    do_reset();
    tu_count = 0;
    for (int n = 1; n <= 11; n++) begin
      step((n == 11) ? DI : PL, (n == 11) ? 1'b1 : 1'b0, 1'b0);
      if (bus.time_up === 1'b1) tu_count++;
    end
    step(DI, 1'b0, 1'b0);
    if (bus.time_up === 1'b1) tu_count++;
    chk("die_at_zero_no_timeup", 64'(tu_count), 64'd0);
    chk("die_at_zero_eat", 64'(bus.score_a), 64'd1);
    step(RS, 1'b0, 1'b0);
    chk("die_at_zero_restart", 64'(bus.active_team), 64'd1);

    // ---------- saturation with SCORE_W=3 ----------
    do_reset();
    sstep(PL, 1'b0);
    for (int k = 0; k < 9; k++) sstep(PL, 1'b1);
    chk("sat_score", 64'(sbus.score_a), 64'd7);
    for (int k = 0; k < 3; k++) sstep(PL, 1'b1);
    chk("sat_hold", 64'(sbus.score_a), 64'd7);
    sstep(RS, 1'b0);

    // ---------- clear_match mid-turn ----------
    do_reset();
    step(PL, 1'b0, 1'b0);
    step(PL, 1'b1, 1'b0);
    step(PL, 1'b1, 1'b0);
    chk("clear_pre_score", 64'(bus.score_a), 64'd2);
    step(PL, 1'b1, 1'b1);
    chk("clear_outputs", pack_out(), 32'h0);
    step(RS, 1'b1, 1'b0);
    chk("clear_in_wait", 64'(bus.score_a), 64'd0);

    // ---------- randomized run against the reference model ----------
    do_reset();
    m_reset();
    st = RS;
    for (int c = 0; c < 3000; c++) begin
      logic eat, clr;
      if ($urandom_range(3, 0) == 0) st = 2'($urandom_range(3, 0));
      eat = ($urandom_range(2, 0) == 0);
      clr = ($urandom_range(399, 0) == 0);
      step(st, eat, clr);
      m_step(st, eat, clr);
      chk($sformatf("rand_c%0d", c), pack_out(), m_pack());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
